// File: rtl/wb_sdram_mctrl.sv
// Wishbone B3 to single-rank 32-bit SDRAM controller with a config register port,
// power-up init sequence, periodic auto-refresh and one closed-page access per beat.
module wb_sdram_mctrl #(
    parameter int unsigned REF_RST = 780
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [31:0] wb_adr_i,
    input  logic [31:0] wb_dat_i,
    input  logic [3:0]  wb_sel_i,
    input  logic        wb_cyc_i,
    input  logic        wb_stb_i,
    input  logic        wb_we_i,
    input  logic [1:0]  wb_bte_i,
    input  logic [2:0]  wb_cti_i,
    output logic [31:0] wb_dat_o,
    output logic        wb_ack_o,
    output logic        wb_err_o,
    output logic        wb_rty_o,
    input  logic [2:0]  cfg_adr_i,
    input  logic [31:0] cfg_dat_i,
    input  logic        cfg_cyc_i,
    input  logic        cfg_stb_i,
    input  logic        cfg_we_i,
    output logic        cfg_ack_o,
    output logic [31:0] cfg_dat_o,
    output logic        cacheable,
    input  logic [31:0] memi_data,
    output logic [31:0] memo_data,
    output logic [31:0] memo_vbdrive,
    output logic [31:0] memo_address,
    output logic [1:0]  sdo_sdcke,
    output logic [1:0]  sdo_sdcsn,
    output logic        sdo_rasn,
    output logic        sdo_casn,
    output logic        sdo_sdwen,
    output logic [7:0]  sdo_dqm
);
    localparam int unsigned CNT_W = 4;
    localparam int unsigned REF_W = 15;
    localparam int unsigned WA_W  = 21;

    localparam logic [2:0] CMD_NOP = 3'b111;
    localparam logic [2:0] CMD_ACT = 3'b011;
    localparam logic [2:0] CMD_RD  = 3'b101;
    localparam logic [2:0] CMD_WR  = 3'b100;
    localparam logic [2:0] CMD_PRE = 3'b010;
    localparam logic [2:0] CMD_REF = 3'b001;
    localparam logic [2:0] CMD_LMR = 3'b000;

    typedef enum logic [3:0] {
        S_OFF, S_INIT, S_IDLE, S_ACT, S_RW, S_CASWAIT, S_ACK, S_PRECH, S_REFRESH
    } state_t;

    state_t              state_q, state_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [2:0]          init_q, init_d;
    logic [WA_W-1:0]     adr_q, adr_d;
    logic [31:0]         wdat_q, wdat_d;
    logic [3:0]          sel_q, sel_d;
    logic                we_q, we_d;

    logic                ack_d, err_d;
    logic [31:0]         dat_d, mdata_d, vb_d, maddr_d;
    logic [2:0]          cmd_d;
    logic [3:0]          dqm_d;
    logic                cmd_clr, ref_clr;

    logic [31:0]         cfg0_q, cfg1_q, cfg_rd;
    logic [REF_W-1:0]    cfg2_q, ref_cnt_q;
    logic                ref_pend_q;

    logic                se, ref_en, in_region, wb_req;
    logic [CNT_W-1:0]    t_rp, t_rcd, t_rfc, t_cas;
    logic [10:0]         lmr_a;

    logic                unused_ok;
    assign unused_ok = ^{wb_bte_i, wb_cti_i, wb_adr_i[28:23], wb_adr_i[1:0]};

    assign wb_rty_o  = 1'b0;
    assign se        = cfg1_q[14];
    assign ref_en    = cfg1_q[31];
    assign in_region = (wb_adr_i[31:29] == 3'b011);
    assign wb_req    = wb_cyc_i & wb_stb_i;
    assign t_rp      = cfg1_q[30] ? CNT_W'(3) : CNT_W'(2);
    assign t_rcd     = t_rp;
    assign t_rfc     = CNT_W'(cfg1_q[29:27]) + CNT_W'(3);
    assign t_cas     = cfg1_q[26] ? CNT_W'(3) : CNT_W'(2);
    // mode register: burst length 1, sequential, CAS latency 2 or 3
    assign lmr_a     = {4'b0000, 2'b01, cfg1_q[26], 4'b0000};

    function automatic logic [31:0] mk_addr(input logic [1:0] ba, input logic [10:0] a);
        return {15'd0, ba, 2'b00, a, 2'b00};
    endfunction

    always_comb begin
        cfg_rd = '0;
        case (cfg_adr_i)
            3'd0:    cfg_rd = cfg0_q;
            3'd1:    cfg_rd = cfg1_q;
            3'd2:    cfg_rd = 32'(cfg2_q);
            default: cfg_rd = '0;
        endcase
    end

    // next-state and registered-output logic
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        init_d  = init_q;
        adr_d   = adr_q;
        wdat_d  = wdat_q;
        sel_d   = sel_q;
        we_d    = we_q;
        ack_d   = 1'b0;
        err_d   = wb_req & ~in_region & ~wb_err_o;
        dat_d   = wb_dat_o;
        mdata_d = memo_data;
        vb_d    = '1;
        maddr_d = memo_address;
        cmd_d   = CMD_NOP;
        dqm_d   = 4'hF;
        cmd_clr = 1'b0;
        ref_clr = 1'b0;

        case (state_q)
            S_OFF: begin
                if (se) begin
                    state_d = S_INIT;
                    init_d  = '0;
                    cnt_d   = '0;
                end
            end
            S_INIT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    case (init_q)
                        3'd0: begin
                            cmd_d   = CMD_PRE;
                            maddr_d = mk_addr(2'b00, 11'h400);
                            cnt_d   = t_rp - CNT_W'(1);
                            init_d  = 3'd1;
                        end
                        3'd1, 3'd2: begin
                            cmd_d  = CMD_REF;
                            cnt_d  = t_rfc - CNT_W'(1);
                            init_d = init_q + 3'd1;
                        end
                        3'd3: begin
                            cmd_d   = CMD_LMR;
                            maddr_d = mk_addr(2'b00, lmr_a);
                            cnt_d   = CNT_W'(1);
                            init_d  = 3'd4;
                        end
                        default: state_d = S_IDLE;
                    endcase
                end
            end
            S_IDLE: begin
                // software commands first, then refresh, then data-port traffic
                if (cfg1_q[20:19] != 2'b00) begin
                    cmd_clr = 1'b1;
                    state_d = S_REFRESH;
                    case (cfg1_q[20:19])
                        2'b01: begin
                            cmd_d   = CMD_PRE;
                            maddr_d = mk_addr(2'b00, 11'h400);
                            cnt_d   = t_rp - CNT_W'(1);
                        end
                        2'b10: begin
                            cmd_d = CMD_REF;
                            cnt_d = t_rfc - CNT_W'(1);
                        end
                        default: begin
                            cmd_d   = CMD_LMR;
                            maddr_d = mk_addr(2'b00, lmr_a);
                            cnt_d   = CNT_W'(1);
                        end
                    endcase
                end else if (ref_pend_q && ref_en) begin
                    cmd_d   = CMD_REF;
                    ref_clr = 1'b1;
                    cnt_d   = t_rfc - CNT_W'(1);
                    state_d = S_REFRESH;
                end else if (wb_req && in_region) begin
                    cmd_d   = CMD_ACT;
                    maddr_d = mk_addr(wb_adr_i[22:21], wb_adr_i[20:10]);
                    adr_d   = wb_adr_i[22:2];
                    wdat_d  = wb_dat_i;
                    sel_d   = wb_sel_i;
                    we_d    = wb_we_i;
                    cnt_d   = t_rcd - CNT_W'(1);
                    state_d = S_ACT;
                end
            end
            S_ACT: begin
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    maddr_d = mk_addr(adr_q[20:19], {3'b100, adr_q[7:0]});
                    state_d = S_RW;
                    if (we_q) begin
                        cmd_d   = CMD_WR;
                        mdata_d = wdat_q;
                        vb_d    = '0;
                        dqm_d   = ~sel_q;
                    end else begin
                        cmd_d = CMD_RD;
                        dqm_d = 4'h0;
                    end
                end
            end
            S_RW: begin
                if (we_q) begin
                    ack_d   = wb_req;
                    state_d = S_ACK;
                end else begin
                    dqm_d   = 4'h0;
                    cnt_d   = t_cas - CNT_W'(1);
                    state_d = S_CASWAIT;
                end
            end
            S_CASWAIT: begin
                dqm_d = 4'h0;
                if (cnt_q != '0) begin
                    cnt_d = cnt_q - CNT_W'(1);
                end else begin
                    dat_d   = memi_data;
                    ack_d   = wb_req;
                    state_d = S_ACK;
                end
            end
            S_ACK: begin
                cnt_d   = t_rp - CNT_W'(1);
                state_d = S_PRECH;
            end
            S_PRECH, S_REFRESH: begin
                if (cnt_q != '0) cnt_d = cnt_q - CNT_W'(1);
                else             state_d = S_IDLE;
            end
            default: state_d = S_OFF;
        endcase

        if (!se) begin
            state_d = S_OFF;
            cmd_d   = CMD_NOP;
            ack_d   = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= S_OFF;
            cnt_q        <= '0;
            init_q       <= '0;
            adr_q        <= '0;
            wdat_q       <= '0;
            sel_q        <= '0;
            we_q         <= 1'b0;
            wb_ack_o     <= 1'b0;
            wb_err_o     <= 1'b0;
            wb_dat_o     <= '0;
            memo_data    <= '0;
            memo_vbdrive <= '1;
            memo_address <= '0;
            sdo_sdcke    <= 2'b11;
            sdo_sdcsn    <= 2'b11;
            {sdo_rasn, sdo_casn, sdo_sdwen} <= CMD_NOP;
            sdo_dqm      <= '1;
        end else begin
            state_q      <= state_d;
            cnt_q        <= cnt_d;
            init_q       <= init_d;
            adr_q        <= adr_d;
            wdat_q       <= wdat_d;
            sel_q        <= sel_d;
            we_q         <= we_d;
            wb_ack_o     <= ack_d;
            wb_err_o     <= err_d;
            wb_dat_o     <= dat_d;
            memo_data    <= mdata_d;
            memo_vbdrive <= vb_d;
            memo_address <= maddr_d;
            sdo_sdcke    <= 2'b11;
            sdo_sdcsn    <= {1'b1, ~se};
            {sdo_rasn, sdo_casn, sdo_sdwen} <= cmd_d;
            sdo_dqm      <= {4'hF, dqm_d};
        end
    end

    // config registers and refresh interval counter
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cfg0_q     <= '0;
            cfg1_q     <= '0;
            cfg2_q     <= REF_W'(REF_RST);
            cfg_ack_o  <= 1'b0;
            cfg_dat_o  <= '0;
            cacheable  <= 1'b0;
            ref_cnt_q  <= REF_W'(REF_RST);
            ref_pend_q <= 1'b0;
        end else begin
            cfg_ack_o <= cfg_cyc_i & cfg_stb_i & ~cfg_ack_o;
            cfg_dat_o <= cfg_rd;
            cacheable <= in_region;
            if (cmd_clr) cfg1_q[20:19] <= 2'b00;
            if (cfg_ack_o && cfg_we_i) begin
                case (cfg_adr_i)
                    3'd0:    cfg0_q <= cfg_dat_i;
                    3'd1:    cfg1_q <= cfg_dat_i;
                    3'd2:    cfg2_q <= cfg_dat_i[REF_W-1:0];
                    default: ;
                endcase
            end
            if (ref_clr) ref_pend_q <= 1'b0;
            if (se && ref_en) begin
                if (ref_cnt_q == '0) begin
                    ref_cnt_q  <= cfg2_q;
                    ref_pend_q <= 1'b1;
                end else begin
                    ref_cnt_q <= ref_cnt_q - REF_W'(1);
                end
            end else begin
                ref_cnt_q <= cfg2_q;
            end
        end
    end

endmodule

// File: tb/tb_wb_sdram_mctrl.sv
// Directed bench for wb_sdram_mctrl: behavioural SDRAM model, reference memory and
// read-data scoreboard queue.
module tb_wb_sdram_mctrl;
    localparam logic [31:0] CFG1_VAL = 32'hB900_4C20;

    logic        clk = 1'b0;
    logic        rst;
    logic [31:0] wb_adr_i, wb_dat_i, wb_dat_o;
    logic [3:0]  wb_sel_i;
    logic        wb_cyc_i, wb_stb_i, wb_we_i;
    logic [1:0]  wb_bte_i;
    logic [2:0]  wb_cti_i;
    logic        wb_ack_o, wb_err_o, wb_rty_o;
    logic [2:0]  cfg_adr_i;
    logic [31:0] cfg_dat_i, cfg_dat_o;
    logic        cfg_cyc_i, cfg_stb_i, cfg_we_i, cfg_ack_o;
    logic        cacheable;
    logic [31:0] memi_data = 32'hDEAD_BEEF;
    logic [31:0] memo_data, memo_vbdrive, memo_address;
    logic [1:0]  sdo_sdcke, sdo_sdcsn;
    logic        sdo_rasn, sdo_casn, sdo_sdwen;
    logic [7:0]  sdo_dqm;

    always #5 clk = ~clk;

    wb_sdram_mctrl #(.REF_RST(780)) dut (
        .clk(clk), .rst(rst),
        .wb_adr_i(wb_adr_i), .wb_dat_i(wb_dat_i), .wb_sel_i(wb_sel_i),
        .wb_cyc_i(wb_cyc_i), .wb_stb_i(wb_stb_i), .wb_we_i(wb_we_i),
        .wb_bte_i(wb_bte_i), .wb_cti_i(wb_cti_i),
        .wb_dat_o(wb_dat_o), .wb_ack_o(wb_ack_o), .wb_err_o(wb_err_o), .wb_rty_o(wb_rty_o),
        .cfg_adr_i(cfg_adr_i), .cfg_dat_i(cfg_dat_i), .cfg_cyc_i(cfg_cyc_i),
        .cfg_stb_i(cfg_stb_i), .cfg_we_i(cfg_we_i), .cfg_ack_o(cfg_ack_o), .cfg_dat_o(cfg_dat_o),
        .cacheable(cacheable), .memi_data(memi_data), .memo_data(memo_data),
        .memo_vbdrive(memo_vbdrive), .memo_address(memo_address),
        .sdo_sdcke(sdo_sdcke), .sdo_sdcsn(sdo_sdcsn),
        .sdo_rasn(sdo_rasn), .sdo_casn(sdo_casn), .sdo_sdwen(sdo_sdwen), .sdo_dqm(sdo_dqm)
    );

    typedef struct {
        logic [2:0]  c;
        int          t;
        logic [10:0] a;
    } cmd_rec_t;

    int          n_cmp = 0;
    int          n_bad = 0;
    int          cyc_n = 0;
    int          cas_cfg = 2;
    int          n_access = 0;
    int          trcd_viol = 0;
    int          rd_wait = 0;
    logic [31:0] rd_val;
    logic [31:0] mem [int];
    logic [31:0] ref_mem [int];
    logic [10:0] open_row [4];
    int          act_cyc [4];
    logic [3:0]  last_wr_dqm = 4'hF;
    logic [31:0] last_wr_vb = '1;
    cmd_rec_t    cmd_log [$];
    int          ref_log [$];
    logic [31:0] exp_q [$];

    logic [2:0]  cmd;
    logic [1:0]  m_ba;
    logic [10:0] m_a;
    assign cmd  = {sdo_rasn, sdo_casn, sdo_sdwen};
    assign m_ba = memo_address[16:15];
    assign m_a  = memo_address[12:2];

    always @(posedge clk) cyc_n <= cyc_n + 1;

    // SDRAM model: commands sampled mid-cycle, read data returned CAS cycles later
    always @(negedge clk) begin
        int          key;
        logic [31:0] w;
        memi_data = 32'hDEAD_BEEF;
        if (rd_wait > 0) begin
            rd_wait = rd_wait - 1;
            if (rd_wait == 0) memi_data = rd_val;
        end
        if (!rst && sdo_sdcsn[0] == 1'b0 && cmd != 3'b111) begin
            cmd_log.push_back('{c: cmd, t: cyc_n, a: m_a});
            case (cmd)
                3'b011: begin
                    open_row[m_ba] = m_a;
                    act_cyc[m_ba]  = cyc_n;
                    n_access++;
                end
                3'b100: begin
                    n_access++;
                    if (cyc_n - act_cyc[m_ba] < 2) trcd_viol++;
                    key = int'({m_ba, open_row[m_ba], m_a[7:0]});
                    w = mem.exists(key) ? mem[key] : 32'h0;
                    for (int b = 0; b < 4; b++)
                        if (!sdo_dqm[b]) w[b*8 +: 8] = memo_data[b*8 +: 8];
                    mem[key]    = w;
                    last_wr_dqm = sdo_dqm[3:0];
                    last_wr_vb  = memo_vbdrive;
                end
                3'b101: begin
                    n_access++;
                    if (cyc_n - act_cyc[m_ba] < 2) trcd_viol++;
                    key = int'({m_ba, open_row[m_ba], m_a[7:0]});
                    rd_val  = mem.exists(key) ? mem[key] : 32'h0;
                    rd_wait = cas_cfg;
                end
                3'b001: ref_log.push_back(cyc_n);
                default: ;
            endcase
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cfg_xfer(input logic we, input logic [2:0] adr, input logic [31:0] dat,
                            output logic [31:0] rdata);
        logic got;
        @(posedge clk); #1;
        cfg_cyc_i = 1'b1; cfg_stb_i = 1'b1; cfg_we_i = we; cfg_adr_i = adr; cfg_dat_i = dat;
        got = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (cfg_ack_o) begin got = 1'b1; break; end
        end
        check("cfg_ack", 32'(got), 32'd1);
        rdata = cfg_dat_o;
        @(posedge clk); #1;
        cfg_cyc_i = 1'b0; cfg_stb_i = 1'b0; cfg_we_i = 1'b0;
        @(negedge clk);
        check("cfg_ack_pulse", 32'(cfg_ack_o), 32'd0);
    endtask

    task automatic wb_beat(input string tag, input logic we, input logic [31:0] adr,
                           input logic [31:0] dat, input logic [3:0] sel,
                           input logic [2:0] cti, input logic last);
        logic        got;
        logic [31:0] w, e;
        int          key;
        @(posedge clk); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = we; wb_adr_i = adr;
        wb_dat_i = dat; wb_sel_i = sel; wb_cti_i = cti;
        key = int'(adr[22:2]);
        w = ref_mem.exists(key) ? ref_mem[key] : 32'h0;
        if (we) begin
            for (int b = 0; b < 4; b++) if (sel[b]) w[b*8 +: 8] = dat[b*8 +: 8];
            ref_mem[key] = w;
        end else begin
            exp_q.push_back(w);
        end
        got = 1'b0;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk);
            if (wb_ack_o) begin got = 1'b1; break; end
        end
        check({tag, "_ack"}, 32'(got), 32'd1);
        if (!we) begin
            e = exp_q.pop_front();
            if (got) check({tag, "_rdata"}, wb_dat_o, e);
        end
        if (last) begin
            @(posedge clk); #1;
            wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0; wb_cti_i = 3'b000;
            @(negedge clk);
            check({tag, "_ack_pulse"}, 32'(wb_ack_o), 32'd0);
        end
    endtask

    initial begin
        logic [31:0] rd;
        logic        seen_err, seen_ack;
        int          n0, d;

        rst = 1'b1;
        wb_adr_i = '0; wb_dat_i = '0; wb_sel_i = '0; wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        wb_we_i = 1'b0; wb_bte_i = 2'b00; wb_cti_i = 3'b000;
        cfg_adr_i = '0; cfg_dat_i = '0; cfg_cyc_i = 1'b0; cfg_stb_i = 1'b0; cfg_we_i = 1'b0;
        repeat (3) @(negedge clk);
        check("rst_ack", 32'(wb_ack_o), 32'd0);
        check("rst_err", 32'(wb_err_o), 32'd0);
        check("rst_rty", 32'(wb_rty_o), 32'd0);
        check("rst_dat", wb_dat_o, 32'd0);
        check("rst_cmd", 32'(cmd), 32'd7);
        check("rst_cke", 32'(sdo_sdcke), 32'd3);
        check("rst_csn", 32'(sdo_sdcsn), 32'd3);
        check("rst_dqm", 32'(sdo_dqm), 32'hFF);
        check("rst_vb", memo_vbdrive, 32'hFFFF_FFFF);
        check("rst_addr", memo_address, 32'd0);
        @(posedge clk); #1;
        rst = 1'b0;

        cfg_xfer(1'b0, 3'd0, 32'd0, rd); check("cfg0_rst", rd, 32'd0);
        cfg_xfer(1'b0, 3'd1, 32'd0, rd); check("cfg1_rst", rd, 32'd0);
        cfg_xfer(1'b0, 3'd2, 32'd0, rd); check("cfg2_rst", rd, 32'd780);
        cfg_xfer(1'b1, 3'd0, 32'h1234_5678, rd);
        cfg_xfer(1'b0, 3'd0, 32'd0, rd); check("cfg0_rw", rd, 32'h1234_5678);
        cfg_xfer(1'b1, 3'd5, 32'hFFFF_FFFF, rd);
        cfg_xfer(1'b0, 3'd5, 32'd0, rd); check("cfg5_zero", rd, 32'd0);

        // enable SDRAM: init sequence PRE, REF, REF, LMR with tRP=2, tRFC=10, CAS 2
        cmd_log.delete();
        cas_cfg = 2;
        cfg_xfer(1'b1, 3'd1, CFG1_VAL, rd);
        cfg_xfer(1'b0, 3'd1, 32'd0, rd); check("cfg1_rb", rd, CFG1_VAL);
        repeat (40) @(negedge clk);
        check("csn_se", 32'(sdo_sdcsn), 32'd2);
        check("init_ncmd", 32'(cmd_log.size() >= 4), 32'd1);
        if (cmd_log.size() >= 4) begin
            check("init_pre", 32'(cmd_log[0].c), 32'd2);
            check("init_pre_a10", 32'(cmd_log[0].a[10]), 32'd1);
            check("init_ref1", 32'(cmd_log[1].c), 32'd1);
            check("init_ref2", 32'(cmd_log[2].c), 32'd1);
            check("init_lmr", 32'(cmd_log[3].c), 32'd0);
            check("lmr_cas", 32'(cmd_log[3].a[6:4]), 32'd2);
            check("lmr_bl", 32'(cmd_log[3].a[3:0]), 32'd0);
            check("init_trp", 32'(cmd_log[1].t - cmd_log[0].t), 32'd2);
            check("init_trfc1", 32'(cmd_log[2].t - cmd_log[1].t), 32'd10);
            check("init_trfc2", 32'(cmd_log[3].t - cmd_log[2].t), 32'd10);
        end

        // classic single writes, then read back
        wb_beat("cw0", 1'b1, 32'h6000_0000, 32'd0, 4'hF, 3'b000, 1'b1);
        wb_beat("cw1", 1'b1, 32'h6000_0004, 32'd1, 4'hF, 3'b000, 1'b1);
        wb_beat("cw2", 1'b1, 32'h6000_0008, 32'd2, 4'hF, 3'b000, 1'b1);
        wb_beat("cr0", 1'b0, 32'h6000_0000, 32'd0, 4'hF, 3'b000, 1'b1);
        check("cacheable_hi", 32'(cacheable), 32'd1);

        // incrementing bursts
        for (int i = 0; i < 5; i++)
            wb_beat("bw", 1'b1, 32'h6000_0000 + 32'(i * 4), 32'(i), 4'hF,
                    (i == 4) ? 3'b111 : 3'b010, i == 4);
        for (int i = 0; i < 5; i++)
            wb_beat("br", 1'b0, 32'h6000_0000 + 32'(i * 4), 32'd0, 4'hF,
                    (i == 4) ? 3'b111 : 3'b010, i == 4);

        // byte-lane write
        wb_beat("sw_full", 1'b1, 32'h6000_1000, 32'h1122_3344, 4'hF, 3'b000, 1'b1);
        wb_beat("sw_lane", 1'b1, 32'h6000_1000, 32'hAABB_CCDD, 4'b0010, 3'b000, 1'b1);
        check("wr_dqm", 32'(last_wr_dqm), 32'hD);
        check("wr_vbdrive", last_wr_vb, 32'd0);
        wb_beat("sr", 1'b0, 32'h6000_1000, 32'd0, 4'hF, 3'b000, 1'b1);
        wb_beat("bank3w", 1'b1, 32'h6060_0404, 32'hCAFE_F00D, 4'hF, 3'b000, 1'b1);
        wb_beat("bank3r", 1'b0, 32'h6060_0404, 32'd0, 4'hF, 3'b000, 1'b1);

        // out-of-region access
        n0 = n_access;
        seen_err = 1'b0; seen_ack = 1'b0;
        @(posedge clk); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b0; wb_adr_i = 32'h4000_0000;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            if (wb_ack_o) seen_ack = 1'b1;
            if (wb_err_o) begin seen_err = 1'b1; break; end
        end
        check("err_seen", 32'(seen_err), 32'd1);
        check("cacheable_lo", 32'(cacheable), 32'd0);
        @(posedge clk); #1;
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0;
        @(negedge clk);
        check("err_pulse", 32'(wb_err_o), 32'd0);
        repeat (10) begin
            @(negedge clk);
            if (wb_ack_o) seen_ack = 1'b1;
        end
        check("err_no_ack", 32'(seen_ack), 32'd0);
        check("err_no_cmd", 32'(n_access - n0), 32'd0);

        // idle refresh cadence
        ref_log.delete();
        repeat (2000) @(negedge clk);
        check("ref_count", 32'(ref_log.size() >= 2), 32'd1);
        for (int i = 1; i < ref_log.size(); i++) begin
            d = ref_log[i] - ref_log[i-1];
            check("ref_period", 32'(d), 32'd781);
        end
        check("trcd_ok", 32'(trcd_viol), 32'd0);
        check("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        // reset in the middle of an access
        @(posedge clk); #1;
        wb_cyc_i = 1'b1; wb_stb_i = 1'b1; wb_we_i = 1'b1; wb_adr_i = 32'h6000_0100;
        wb_dat_i = 32'h5555_AAAA; wb_sel_i = 4'hF;
        repeat (3) @(negedge clk);
        rst = 1'b1;
        #1;
        check("mid_rst_cmd", 32'(cmd), 32'd7);
        check("mid_rst_csn", 32'(sdo_sdcsn), 32'd3);
        check("mid_rst_vb", memo_vbdrive, 32'hFFFF_FFFF);
        check("mid_rst_ack", 32'(wb_ack_o), 32'd0);
        wb_cyc_i = 1'b0; wb_stb_i = 1'b0; wb_we_i = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        cfg_xfer(1'b0, 3'd1, 32'd0, rd); check("mid_rst_cfg1", rd, 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
